// File: rtl/keypad_pkg.sv
// Shared widths, FSM encoding and event record for the keypad event scheduler.
package keypad_pkg;
  localparam int NUM_KEYS = 16;
  localparam int KEY_W    = 4;

  typedef enum logic {IDLE, OFFER} kes_state_t;

  typedef struct packed {
    logic [KEY_W-1:0] code;
    logic             press;
    logic             is_repeat;
  } key_event_t;
endpackage

// File: rtl/keypad_event_scheduler_rr_arbiter16.sv
// Round-robin find-first-set: searches upward from ptr, wrapping 15 -> 0.
module rr_arbiter16
  import keypad_pkg::*;
(
  input  logic [NUM_KEYS-1:0] req,
  input  logic [KEY_W-1:0]    ptr,
  output logic                grant_valid,
  output logic [KEY_W-1:0]    grant_idx
);

  logic [KEY_W-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      idx = ptr + KEY_W'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/keypad_event_scheduler.sv
// Converts debounced key levels into a fair, serialized stream of press,
// release and typematic-repeat events on a valid/ready handshake.
module keypad_event_scheduler
  import keypad_pkg::*;
#(
  parameter int TICK_DIV     = 27000,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] button_state,
  input  logic                enable,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [KEY_W-1:0]    ev_code,
  output logic                ev_press,
  output logic                ev_repeat,
  output logic                overflow
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [NUM_KEYS-1:0] prev, pp, rp, rise, fall, eligible, pp_clr, rp_clr;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  kes_state_t          state, state_next;
  logic [KEY_W-1:0]    rr_ptr;
  key_event_t          ev_q, ev_sel;
  logic                grant_valid;
  logic [KEY_W-1:0]    grant_idx;
  logic                sel_any, handshake, press_accept;
  logic                rep_active, rep_pend;
  logic [KEY_W-1:0]    rep_key;
  logic [CNT_W-1:0]    rep_cnt;

  assign rise     = button_state & ~prev;
  assign fall     = ~button_state & prev;
  assign eligible = pp | rp;
  assign tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= button_state;
  end

  rr_arbiter16 u_arb (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Key events beat repeats; a key with both bits pending offers its press first.
  always_comb begin
    ev_sel  = '0;
    sel_any = 1'b0;
    if (enable) begin
      if (grant_valid) begin
        sel_any      = 1'b1;
        ev_sel.code  = grant_idx;
        ev_sel.press = pp[grant_idx];
      end else if (rep_pend) begin
        sel_any          = 1'b1;
        ev_sel.code      = rep_key;
        ev_sel.press     = 1'b1;
        ev_sel.is_repeat = 1'b1;
      end
    end
  end

  assign handshake    = (state == OFFER) && ev_ready;
  assign press_accept = handshake && ev_q.press && !ev_q.is_repeat;

  always_comb begin
    pp_clr = '0;
    rp_clr = '0;
    if (handshake && !ev_q.is_repeat) begin
      if (ev_q.press) pp_clr[ev_q.code] = 1'b1;
      else            rp_clr[ev_q.code] = 1'b1;
    end
  end

  // New edges are OR'd in after the clear, so a same-cycle set survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else if (!enable) begin
      pp <= '0;
      rp <= '0;
    end else begin
      pp <= (pp & ~pp_clr) | rise;
      rp <= (rp & ~rp_clr) | fall;
      if (|((rise & pp & ~pp_clr) | (fall & rp & ~rp_clr))) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          rr_ptr <= '0;
    else if (handshake) rr_ptr <= ev_q.code + KEY_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_active <= 1'b0;
      rep_pend   <= 1'b0;
      rep_key    <= '0;
      rep_cnt    <= '0;
    end else if (!enable) begin
      rep_active <= 1'b0;
      rep_pend   <= 1'b0;
    end else begin
      if (handshake && ev_q.is_repeat) rep_pend <= 1'b0;
      if (press_accept) begin
        rep_active <= 1'b1;
        rep_key    <= ev_q.code;
        rep_cnt    <= CNT_W'(REPEAT_DELAY);
        rep_pend   <= 1'b0;
      end else if (rep_active && fall[rep_key]) begin
        rep_active <= 1'b0;
        rep_pend   <= 1'b0;
      end else if (rep_active && tick && button_state[rep_key]) begin
        if (rep_cnt == CNT_W'(1)) begin
          rep_pend <= 1'b1;
          rep_cnt  <= CNT_W'(REPEAT_RATE);
        end else begin
          rep_cnt <= rep_cnt - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_any)  state_next = OFFER;
      OFFER:   if (ev_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ev_valid = (state == OFFER);
  end

  always_ff @(posedge clk) begin
    if (reset)                       ev_q <= '0;
    else if (state == IDLE && sel_any) ev_q <= ev_sel;
  end

  assign ev_code   = ev_q.code;
  assign ev_press  = ev_q.press;
  assign ev_repeat = ev_q.is_repeat;

endmodule

// File: tb/tb_keypad_event_scheduler.sv
// Randomized and directed bench comparing the scheduler against a cycle-level reference model.
module tb_keypad_event_scheduler;
  localparam int TD = 4;
  localparam int RD = 3;
  localparam int RR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] button_state = '0;
  logic        enable = 1'b1;
  logic        ev_ready = 1'b0;
  logic        ev_valid, ev_press, ev_repeat, overflow;
  logic [3:0]  ev_code;

  int checks = 0;
  int errors = 0;

  keypad_event_scheduler #(.TICK_DIV(TD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset), .button_state(button_state), .enable(enable),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_press(ev_press), .ev_repeat(ev_repeat), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: pending sets, pointer, offered event, repeat timer in ticks.
  bit [15:0] m_prev, m_pp, m_rp;
  int        m_ptr, m_code, m_tick, m_rep_key, m_rep_left;
  bit        m_offer, m_press, m_rep, m_ovf, m_rep_on, m_rep_pend;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input logic [15:0] bs, input bit en, input bit rdy, input bit rst);
    bit hs, found, tick, sel_press, sel_rep;
    int sel_code, k;
    if (rst) begin
      m_prev = '0; m_pp = '0; m_rp = '0; m_ptr = 0; m_code = 0; m_tick = 0;
      m_offer = 0; m_press = 0; m_rep = 0; m_ovf = 0;
      m_rep_on = 0; m_rep_pend = 0; m_rep_key = 0; m_rep_left = 0;
      return;
    end
    hs = m_offer && rdy;
    found = 0; sel_code = 0; sel_press = 0; sel_rep = 0;
    if (!m_offer && en) begin
      for (int n = 0; n < 16; n++) begin
        k = (m_ptr + n) % 16;
        if (!found && (m_pp[k] || m_rp[k])) begin
          found = 1; sel_code = k; sel_press = m_pp[k];
        end
      end
      if (!found && m_rep_pend) begin
        found = 1; sel_code = m_rep_key; sel_press = 1; sel_rep = 1;
      end
    end
    tick = (m_tick == TD - 1);
    if (hs && m_rep) m_rep_pend = 0;
    if (hs && m_press && !m_rep) begin
      m_rep_on = 1; m_rep_key = m_code; m_rep_left = RD; m_rep_pend = 0;
    end else if (m_rep_on && m_prev[m_rep_key] && !bs[m_rep_key]) begin
      m_rep_on = 0; m_rep_pend = 0;
    end else if (m_rep_on && tick && bs[m_rep_key]) begin
      m_rep_left--;
      if (m_rep_left == 0) begin
        m_rep_pend = 1; m_rep_left = RR;
      end
    end
    if (hs && !m_rep) begin
      if (m_press) m_pp[m_code] = 0;
      else         m_rp[m_code] = 0;
    end
    if (en) begin
      for (int j = 0; j < 16; j++) begin
        if (bs[j] && !m_prev[j]) begin
          if (m_pp[j]) m_ovf = 1;
          m_pp[j] = 1;
        end
        if (!bs[j] && m_prev[j]) begin
          if (m_rp[j]) m_ovf = 1;
          m_rp[j] = 1;
        end
      end
    end else begin
      m_pp = '0; m_rp = '0; m_rep_pend = 0; m_rep_on = 0;
    end
    if (hs) begin
      m_ptr = (m_code + 1) % 16;
      m_offer = 0;
    end else if (found) begin
      m_offer = 1; m_code = sel_code; m_press = sel_press; m_rep = sel_rep;
    end
    m_tick = (m_tick + 1) % TD;
    m_prev = bs;
  endtask

  task automatic compareModel();
    checkOutput("ev_valid", ev_valid, m_offer);
    if (m_offer) begin
      checkOutput("ev_code", ev_code, m_code);
      checkOutput("ev_press", ev_press, m_press);
      checkOutput("ev_repeat", ev_repeat, m_rep);
    end
    checkOutput("overflow", overflow, m_ovf);
  endtask

  task automatic applyStimulus(input logic [15:0] bs, input bit en, input bit rdy, input bit rst);
    button_state = bs;
    enable = en;
    ev_ready = rdy;
    reset = rst;
    @(posedge clk);
    #1 modelStep(bs, en, rdy, rst);
    @(negedge clk);
    compareModel();
  endtask

  int rep_seen, valid_seen;
  logic [15:0] rbs;
  bit ren, rrdy, rrst;

  initial begin
    @(negedge clk);
    applyStimulus(16'h0000, 1, 1, 1);
    applyStimulus(16'h0000, 1, 1, 1);
    checkOutput("reset_valid", ev_valid, 0);
    checkOutput("reset_ovf", overflow, 0);

    // Single press: two cycles to ev_valid, exactly one event.
    applyStimulus(16'h0000, 1, 1, 0);
    applyStimulus(16'h0020, 1, 1, 0);
    checkOutput("press5_early", ev_valid, 0);
    applyStimulus(16'h0020, 1, 1, 0);
    checkOutput("press5_valid", ev_valid, 1);
    checkOutput("press5_code", ev_code, 5);
    checkOutput("press5_press", ev_press, 1);
    checkOutput("press5_rep", ev_repeat, 0);
    valid_seen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h0020, 1, 1, 0);
      if (ev_valid) valid_seen++;
    end
    checkOutput("press5_once", valid_seen, 0);
    for (int i = 0; i < 5; i++) applyStimulus(16'h0000, 1, 1, 0);

    // Two keys together, then both released.
    for (int i = 0; i < 6; i++) applyStimulus(16'h8001, 1, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(16'h0000, 1, 1, 0);

    // Held offer with coalesced edges on key 3.
    for (int i = 0; i < 3; i++) applyStimulus(16'h0008, 1, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(16'h0000, 1, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(16'h0008, 1, 0, 0);
    checkOutput("key3_held", ev_code, 3);
    checkOutput("key3_ovf", overflow, 1);
    for (int i = 0; i < 6; i++) applyStimulus(16'h0008, 1, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(16'h0000, 1, 1, 0);

    // Typematic repeat on key 7, then release stops it.
    rep_seen = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'h0080, 1, 1, 0);
      if (ev_valid && ev_repeat) rep_seen++;
    end
    checkOutput("repeat_seen", rep_seen > 2, 1);
    rep_seen = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(16'h0000, 1, 1, 0);
      if (ev_valid && ev_repeat) rep_seen++;
    end
    checkOutput("repeat_stopped", rep_seen, 0);

    // Disable with one event offered and several pending.
    for (int i = 0; i < 3; i++) applyStimulus(16'h0F00, 1, 0, 0);
    applyStimulus(16'h0F00, 0, 0, 0);
    checkOutput("dis_hold", ev_valid, 1);
    applyStimulus(16'h0F00, 0, 1, 0);
    valid_seen = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(16'h0F00 ^ 16'(i * 37), 0, 1, 0);
      if (ev_valid) valid_seen++;
    end
    checkOutput("dis_quiet", valid_seen, 0);
    for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 1, 1, 0);

    // Reset while an event is offered drops it.
    for (int i = 0; i < 3; i++) applyStimulus(16'h0004, 1, 0, 0);
    checkOutput("pre_reset_valid", ev_valid, 1);
    applyStimulus(16'h0004, 1, 0, 1);
    checkOutput("reset_drop", ev_valid, 0);
    checkOutput("reset_drop_code", ev_code, 0);
    for (int i = 0; i < 6; i++) applyStimulus(16'h0004, 1, 1, 0);

    // Random traffic.
    rbs = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rbs[$urandom_range(0, 15)] ^= 1'b1;
      ren  = ($urandom_range(0, 99) > 3);
      rrdy = ($urandom_range(0, 2) != 0);
      rrst = ($urandom_range(0, 499) == 0);
      applyStimulus(rbs, ren, rrdy, rrst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_event_scheduler.md
# keypad_event_scheduler

Turns the debounced 16-key `button_state` vector from the 4×4 matrix scanner into a serialized stream of key events. Events are press, release and typematic repeat. Keys with pending events are shared fairly through a round-robin arbiter. Events are delivered over a valid/ready handshake to the front-panel command logic. The block runs in the 27 MHz system clock domain, directly downstream of the matrix scanner.

## Interface
Parameters:
- `TICK_DIV`, default 27000: clk cycles per repeat tick (1 ms at 27 MHz).
- `REPEAT_DELAY`, default 500: ticks from an accepted press to the first repeat.
- `REPEAT_RATE`, default 100: ticks between subsequent repeats.

Ports:
- `clk`, in, 1: system clock; the block uses this single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `button_state`, in, 16: debounced key levels, 1 = pressed; bit i is key i.
- `enable`, in, 1: 1 = generate events; 0 = flush and suppress.
- `ev_valid`, out, 1: event offered.
- `ev_ready`, in, 1: consumer accepts the event.
- `ev_code`, out, 4: key index.
- `ev_press`, out, 1: 1 = press/repeat; 0 = release.
- `ev_repeat`, out, 1: 1 = typematic repeat.
- `overflow`, out, 1: sticky; set when an edge is coalesced into an already-pending bit of the same kind. Cleared only by reset.

## Operation
- Edge detection:
  - `prev` register is updated every cycle.
  - `rise = button_state & ~prev`, `fall = ~button_state & prev`.
  - When `enable`=1, `rise` ORs into press-pending bitmap `PP[15:0]` and `fall` ORs into release-pending bitmap `RP[15:0]`.
- Per-key ordering:
  - If a key has both PP and RP set, its press is offered first.
  - A key is eligible when PP|RP is set.
- Arbitration:
  - Round-robin over eligible keys, searching upward from `rr_ptr` with wrap 15→0.
  - After a handshake, `rr_ptr` = served index + 1 mod 16.
- Repeat:
  - Repeat is the lowest priority. It is offered only when PP and RP are both all-zero and `rep_pend`=1.
- FSM states:
  - IDLE: if any key is eligible or `rep_pend`=1, latch code/press/repeat into output registers and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `ev_valid`=1 and the outputs are held stable. On `ev_valid && ev_ready`, clear the served pending bit (or `rep_pend`), update `rr_ptr`, and go to IDLE.
- Simultaneous set and clear of the same pending bit in one cycle: set wins. The new edge is kept and `overflow` is not set.
- Typematic repeat:
  - `rep_key` and `rep_cnt` are loaded when a non-repeat press is accepted: `rep_cnt` = REPEAT_DELAY.
  - `rep_cnt` decrements on each tick while `button_state[rep_key]`=1.
  - When it reaches 0: set `rep_pend` and reload REPEAT_RATE.
  - A fall on `rep_key`, or a newer accepted press, cancels or replaces the repeat. A cancel clears `rep_pend` and deactivates the repeat.
- Tick counter: free-running 0..TICK_DIV-1; a tick pulse is produced at wrap.
- `enable`=0:
  - PP, RP, `rep_pend` and the repeat-active flag are cleared every cycle.
  - `prev` still tracks input.
  - An event already in OFFER completes its handshake.

## Timing
- Reset values:
  - Outputs: `ev_valid`=0, `ev_code`=0, `ev_press`=0, `ev_repeat`=0, `overflow`=0.
  - Internal: `prev`=0, PP=RP=0, `rr_ptr`=0, FSM=IDLE, repeat inactive, tick counter=0.
- Keys held through reset produce press events after reset.
- Latency: an input change sampled at edge k sets pending at k; IDLE selects at k+1; `ev_valid`=1 from k+1. Two cycles from input change to `ev_valid`.
- `ev_valid` drops the cycle after the handshake. Maximum throughput is one event per 2 cycles.
- `ev_valid` never deasserts without a handshake, except on reset. Outputs do not change while `ev_valid`=1 and `ev_ready`=0.
- `ev_ready` may be high before `ev_valid`; no combinational path from `ev_ready` to `ev_valid`.
- Reset mid-OFFER drops the event.

## Structure
- Package `keypad_pkg`:
  - `NUM_KEYS`=16, `KEY_W`=4.
  - FSM enum `kes_state_t` {IDLE, OFFER}.
  - Packed struct `key_event_t` {code, press, repeat}.
- Sub-module `rr_arbiter16`: combinational find-first-set from a pointer with wrap. Inputs: 16-bit request vector, 4-bit pointer. Outputs: grant valid, 4-bit index.
- Tick counter, repeat logic and FSM are inline.

## Test plan
- Reset with `button_state`=0x0000, then set 0x0020 → `ev_valid`=1 two cycles later with code 5, press 1, repeat 0. With ready held high, exactly one event.
- Set 0x8001 in one cycle, ready high, `rr_ptr`=0 → events code 0, then code 15. Then set 0x0000 → releases code 0, then code 15.
- With `ev_ready`=0, press then release key 3 → a single pending press is offered and held stable. Press key 3 again before release → `overflow`=1. Raise ready → press 3, then release 3.
- TICK_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2; hold key 7 → press at T, repeat at ~T+12 cycles, then every 8 cycles. Release → release event and no further repeats.
- Deassert `enable` with 4 pending and one in OFFER → the offered event completes and no further events appear. Toggling keys while disabled produces nothing.
- Assert `reset` while `ev_valid`=1 → `ev_valid`=0 next cycle and all state is at reset values.
